// File: rtl/wb_merge.sv
// wb_merge: in-order writeback merge of FIFO-buffered ALU results and a held load result
// Optional WB_TRACE_EN adds trace_* mirror ports and a retire counter.
module wb_merge #(
  parameter int DEPTH = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [4:0]    alu_dest,
  input  logic [DW-1:0] alu_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [4:0]    ld_dest,
  input  logic [DW-1:0] ld_data,
  output logic          rf_we,
  output logic [4:0]    rf_waddr,
  output logic [DW-1:0] rf_wdata,
  input  logic [4:0]    q_raddr1,
  input  logic [4:0]    q_raddr2,
  output logic          busy1,
  output logic          busy2
`ifdef WB_TRACE_EN
  ,
  output logic          trace_valid,
  output logic [4:0]    trace_addr,
  output logic [DW-1:0] trace_data,
  output logic [31:0]   retire_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] fd [DEPTH];
  logic [4:0] fa [DEPTH];
  logic [AW-1:0] rp, wp;
  logic [AW:0] cnt, nxt_cnt, ahead;
  logic hf;
  logic [4:0] hd;
  logic [DW-1:0] hv;
  logic alu_fire, ld_fire, idle, pop, ld_ret, byp_alu, byp_ld, push, hold, ret;
  logic [4:0] ret_dest;
  logic [DW-1:0] ret_data;
  logic [DEPTH-1:0] ev;
  logic b1, b2;
  always_comb begin
    alu_ready = cnt < (AW+1)'(DEPTH);
    alu_fire = alu_valid & alu_ready;
    idle = (cnt == '0) & ~hf;
    pop = (cnt != '0) & ((ahead != '0) | ~hf);
    ld_ret = hf & (ahead == '0);
    ld_ready = ~hf | ld_ret;
    ld_fire = ld_valid & ld_ready;
    // with nothing pending the oldest incoming result skips the queue entirely
    byp_alu = idle & alu_fire;
    byp_ld = idle & ~alu_fire & ld_fire;
    push = alu_fire & ~byp_alu;
    hold = ld_fire & ~byp_ld;
    ret = pop | ld_ret | byp_alu | byp_ld;
    ret_dest = pop ? fa[rp] : ld_ret ? hd : byp_alu ? alu_dest : ld_dest;
    ret_data = pop ? fd[rp] : ld_ret ? hv : byp_alu ? alu_data : ld_data;
    nxt_cnt = cnt + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_comb begin
    ev = '0;
    b1 = hf & (hd == q_raddr1);
    b2 = hf & (hd == q_raddr2);
    for (int i = 0; i < DEPTH; i++) begin
      ev[i] = {1'b0, AW'(i) - rp} < cnt;
      b1 = b1 | (ev[i] & (fa[i] == q_raddr1));
      b2 = b2 | (ev[i] & (fa[i] == q_raddr2));
    end
    busy1 = (q_raddr1 != '0) & b1;
    busy2 = (q_raddr2 != '0) & b2;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fd[wp] <= alu_data;
      fa[wp] <= alu_dest;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rp <= '0;
      wp <= '0;
      cnt <= '0;
      ahead <= '0;
      hf <= 1'b0;
      hd <= '0;
      hv <= '0;
      rf_we <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= nxt_cnt;
      // ahead counts FIFO entries older than the held load
      if (hold) begin
        hf <= 1'b1;
        hd <= ld_dest;
        hv <= ld_data;
        ahead <= nxt_cnt;
      end else begin
        if (ld_ret) hf <= 1'b0;
        if (pop && ahead != '0) ahead <= ahead - (AW+1)'(1);
      end
      rf_we <= ret & (ret_dest != '0);
      if (ret) begin
        rf_waddr <= ret_dest;
        rf_wdata <= ret_data;
      end
    end
  end
`ifdef WB_TRACE_EN
  assign trace_valid = rf_we;
  assign trace_addr = rf_waddr;
  assign trace_data = rf_wdata;
  always_ff @(posedge clk) begin
    if (rst) retire_cnt <= '0;
    else if (rf_we) retire_cnt <= retire_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_wb_merge.sv
// tb_wb_merge: randomized and directed bench for wb_merge against an arrival-order queue model
module tb_wb_merge;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1;
  logic alu_valid = 0, ld_valid = 0;
  logic alu_ready, ld_ready, rf_we, busy1, busy2;
  logic [4:0] alu_dest = 0, ld_dest = 0, q_raddr1 = 0, q_raddr2 = 0, rf_waddr;
  logic [31:0] alu_data = 0, ld_data = 0, rf_wdata;
`ifdef WB_TRACE_EN
  logic trace_valid;
  logic [4:0] trace_addr;
  logic [31:0] trace_data, retire_cnt;
`endif
  wb_merge #(.DEPTH(DEPTH), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dest(ld_dest), .ld_data(ld_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_raddr1(q_raddr1), .q_raddr2(q_raddr2), .busy1(busy1), .busy2(busy2)
`ifdef WB_TRACE_EN
    , .trace_valid(trace_valid), .trace_addr(trace_addr), .trace_data(trace_data),
    .retire_cnt(retire_cnt)
`endif
  );
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] d;
    logic [31:0] v;
    bit ld;
  } ent_t;
  ent_t pq[$];
  logic [4:0] wl[$];
  logic [31:0] dl[$];
  int checks = 0, failures = 0;
  bit obs_ar, obs_b1, obs_b2, saw_full;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1; alu_valid = 0; ld_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    pq.delete();
  endtask

  // one clock: drive, check handshake/busy, retire oldest pending-or-incoming, check output
  task automatic cyc(input bit av, input logic [4:0] ad, input logic [31:0] adv,
                     input bit lv, input logic [4:0] lds, input logic [31:0] ldv,
                     input logic [4:0] q1, input logic [4:0] q2);
    int na;
    bit ldpend, e_ar, e_lr, e_b1, e_b2, have;
    ent_t r;
    alu_valid = av; alu_dest = ad; alu_data = adv;
    ld_valid = lv; ld_dest = lds; ld_data = ldv;
    q_raddr1 = q1; q_raddr2 = q2;
    #1;
    na = 0; ldpend = 0; e_b1 = 0; e_b2 = 0;
    foreach (pq[i]) begin
      if (pq[i].ld) ldpend = 1; else na++;
      if (q1 != 0 && pq[i].d == q1) e_b1 = 1;
      if (q2 != 0 && pq[i].d == q2) e_b2 = 1;
    end
    e_ar = na < DEPTH;
    e_lr = !ldpend || pq[0].ld;
    chk("alu_ready", alu_ready, e_ar);
    chk("ld_ready", ld_ready, e_lr);
    chk("busy1", busy1, e_b1);
    chk("busy2", busy2, e_b2);
    obs_ar = alu_ready; obs_b1 = busy1; obs_b2 = busy2;
    if (av && e_ar) pq.push_back('{ad, adv, 1'b0});
    if (lv && e_lr) pq.push_back('{lds, ldv, 1'b1});
    have = pq.size() > 0;
    if (have) r = pq.pop_front();
    @(posedge clk); #1;
    chk("rf_we", rf_we, have && r.d != 0);
    if (have && r.d != 0) begin
      chk("rf_waddr", rf_waddr, r.d);
      chk("rf_wdata", rf_wdata, r.v);
      wl.push_back(rf_waddr);
      dl.push_back(rf_wdata);
    end
`ifdef WB_TRACE_EN
    chk("trace_valid", trace_valid, have && r.d != 0);
`endif
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && pq.size() > 0; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    do_reset();
    #1;
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_ld_ready", ld_ready, 1);
    // bypass latency
    cyc(1, 3, 32'h11, 0, 0, 0, 0, 0);
    chk("t1_we", rf_we, 1);
    chk("t1_waddr", rf_waddr, 3);
    chk("t1_wdata", rf_wdata, 32'h11);
    // fill the FIFO while a load keeps the output busy
    saw_full = 0;
    for (int k = 0; k < 24; k++) begin
      cyc(1, 5'(k % 8), 32'h100 + k, 1, 5'(8 + k % 8), 32'h200 + k, 0, 0);
      if (!obs_ar) saw_full = 1;
    end
    chk("t2_full_seen", saw_full, 1);
    drain();
    // arrival order with a load interleaved
    wl.delete(); dl.delete();
    cyc(1, 5, 32'h50, 0, 0, 0, 0, 0);
    cyc(1, 6, 32'h60, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 5, 32'hAA, 0, 0);
    cyc(1, 7, 32'h70, 0, 0, 0, 0, 0);
    drain();
    chk("t3_nwrites", wl.size(), 4);
    if (wl.size() == 4) begin
      chk("t3_w0", wl[0], 5);
      chk("t3_w1", wl[1], 6);
      chk("t3_w2", wl[2], 5);
      chk("t3_d2", dl[2], 32'hAA);
      chk("t3_w3", wl[3], 7);
    end
    // busy on held load
    cyc(1, 1, 32'h1, 1, 9, 32'h99, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 9, 0);
    chk("t4_busy_pend", obs_b1, 1);
    chk("t4_busy2_r0", obs_b2, 0);
    chk("t4_we9", rf_waddr, 9);
    cyc(0, 0, 0, 0, 0, 0, 9, 0);
    chk("t4_busy_clear", obs_b1, 0);
    // r0 destination
    cyc(1, 0, 32'hFF, 0, 0, 0, 0, 0);
    chk("t5_we", rf_we, 0);
    // randomized traffic
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    // reset mid-operation
    for (int k = 0; k < 6; k++) cyc(1, 5'(k + 1), k, 1, 5'(k + 10), k, 0, 0);
    do_reset();
    #1;
    chk("t6_alu_ready", alu_ready, 1);
    chk("t6_ld_ready", ld_ready, 1);
`ifdef WB_TRACE_EN
    chk("t6_retire_cnt", retire_cnt, 0);
`endif
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
